// File: rtl/helper_axis_generator.sv
// helper_axis_generator: AXI-Stream source emitting START_VALUE + k*STEP with periodic/final last flags.
// Define HELPER_AXIS_GENERATOR_STALL_EN to insert LFSR-driven bubbles between words.
module helper_axis_generator #(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned START_VALUE = 0,
    parameter int unsigned STEP        = 1,
    parameter int unsigned WORD_COUNT  = 16,
    parameter int unsigned LAST_PERIOD = 0,
    parameter logic [15:0] STALL_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_last,
    input  logic                  output_ready,
    output logic                  done,
    output logic [31:0]           data_produced
);
    localparam logic [DATA_WIDTH-1:0] START_W = DATA_WIDTH'(START_VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP_W  = DATA_WIDTH'(STEP);

    if (STALL_SEED == 16'h0) begin : g_bad_seed
        $error("STALL_SEED must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           idx_q, idx_d, per_q, per_d, cnt_q, cnt_d;
    logic                  start, hs, final_word, period_end;

`ifdef HELPER_AXIS_GENERATOR_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    // Right-shifting form of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign start  = enable && !lfsr_q[0];
    always_ff @(posedge clk) lfsr_q <= rst ? STALL_SEED : lfsr_d;
`else
    assign start = enable;
`endif

    assign hs         = state_q == SEND && output_ready;
    assign final_word = WORD_COUNT != 0 && idx_q == WORD_COUNT - 1;
    assign period_end = LAST_PERIOD != 0 && per_q == LAST_PERIOD - 1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = start ? SEND : IDLE;
            SEND: if (hs) begin
                cnt_d   = cnt_q + 32'd1;
                data_d  = data_q + STEP_W;
                idx_d   = idx_q + 32'd1;
                per_d   = (period_end || LAST_PERIOD == 0) ? 32'd0 : per_q + 32'd1;
                state_d = final_word ? DONE : start ? SEND : IDLE;
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= START_W;
            idx_q   <= '0;
            per_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
        end
    end

    assign output_valid  = state_q == SEND;
    assign output_data   = data_q;
    assign output_last   = period_end || final_word;
    assign done          = state_q == DONE;
    assign data_produced = cnt_q;
endmodule

// File: doc/helper_axis_generator.md
# helper_axis_generator

Test-bench helper that acts as an AXI-Stream source. It produces a deterministic, parameterised sequence of data words with a last flag, and drives them into a device under test. It is the transmitter-side counterpart of the AXIS drain helper and is used to feed DUT inputs in directed and soak tests. It counts completed transfers and flags completion.

## Interface
- DATA_WIDTH, 10, width of output_data.
- START_VALUE, 0, value of the first word, truncated to DATA_WIDTH.
- STEP, 1, increment between consecutive words, modulo 2^DATA_WIDTH.
- WORD_COUNT, 16, words to send before stopping; 0 = unbounded stream.
- LAST_PERIOD, 0, output_last asserted every LAST_PERIOD words; 0 = only on the final word of a bounded stream.
- STALL_SEED, 16'hACE1, LFSR seed, used only with stall insertion compiled in; must be nonzero.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  permission to start presenting a new word.
- output_valid  output  1  AXIS valid.
- output_data  output  DATA_WIDTH  AXIS data.
- output_last  output  1  AXIS last.
- output_ready  input  1  AXIS ready from the consumer.
- done  output  1  high once all WORD_COUNT words have been accepted.
- data_produced  output  32  number of completed handshakes (wraps at 2^32).

## Operation
- Word index k starts at 0. The word presented is data = (START_VALUE + k*STEP) mod 2^DATA_WIDTH, held in an accumulator register rather than computed with a multiplier.
- last = (LAST_PERIOD != 0 && (k+1) mod LAST_PERIOD == 0) || (WORD_COUNT != 0 && k == WORD_COUNT-1). Uses a separate period counter that resets to 0 on wrap.
- FSM states:
  - IDLE: valid=0. Moves to SEND when the start condition holds.
  - SEND: valid=1, with data and last stable.
  - DONE: valid=0 and done=1. Terminal until rst.
- Start condition: enable=1. With stall insertion compiled in, lfsr[0]=0 is also required.
- Transitions out of SEND on a handshake (valid && ready):
  - If this was the final word of a bounded stream, go to DONE.
  - Otherwise, if the start condition holds, stay in SEND and present word k+1.
  - Otherwise, go to IDLE with word k+1 staged.
- SEND with no handshake stays in SEND. valid, data and last must not change, even if enable drops.
- data_produced increments by 1 on every handshake.
- With WORD_COUNT=0 the stream never finishes: done stays 0 and the index and data wrap silently.
- output_ready is ignored when valid=0.

## Timing
- Reset values: output_valid=0, output_data=START_VALUE truncated, output_last=the value for k=0, done=0, data_produced=0, state IDLE, LFSR=STALL_SEED.
- rst has priority over every other input. Asserting it mid-transfer drops valid on the next edge and restarts the sequence from k=0.
- Latency: if enable=1 at the first edge after rst is released, valid is high on the following cycle. There is one cycle of latency from enable to valid.
- Throughput: one word per cycle while ready=1 and the start condition holds continuously.
- done rises in the cycle after the final handshake, and valid falls in the same cycle.
- If a handshake and enable falling happen in the same cycle, the handshake completes and valid drops on the next cycle.

## Configuration
- HELPER_AXIS_GENERATOR_STALL_EN
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle after reset. A new word may start only when lfsr[0]=0. This inserts pseudo-random bubbles but never withdraws a pending valid.
  - Undefined: the LFSR logic is absent and the start condition is enable alone.

## Test plan
- Defaults, enable=1 and ready=1 throughout:
  - valid rises 1 cycle after reset and data runs 0..15 back-to-back with no gaps.
  - last is high only on 15.
  - done=1 and data_produced=16 in the cycle after the word 15 handshake, with valid=0.
- ready held low for 5 cycles while word 3 is presented, and enable dropped during that time:
  - valid stays 1 and data stays 3 for all 5 cycles.
  - After ready=1, valid drops and data_produced=4.
- START_VALUE=1020, STEP=3, DATA_WIDTH=10, WORD_COUNT=4: data is 1020, 1023, 2, 5.
- LAST_PERIOD=4, WORD_COUNT=0, 12 words: last is high on k=3, 7, 11; done stays 0.
- rst pulsed for 1 cycle while word 6 is pending: outputs return to their reset values, then the stream restarts at data=0.
- With HELPER_AXIS_GENERATOR_STALL_EN defined and ready=1:
  - 16 words arrive, with gap cycles matching the LFSR from seed ACE1.
  - No valid ever falls before its handshake.
